// File: rtl/icap16_pkg.sv
// ---------------------------------------------------------------------------
// icap16_pkg
// Shared definitions for the 16-bit ICAP command sequencer:
//   - ICAP16 configuration-packet constants (sync words, headers, commands)
//   - sequencer FSM state encoding
//   - word-ROM stream selector
// ---------------------------------------------------------------------------
package icap16_pkg;

  localparam logic [15:0] ICAP_DUMMY   = 16'hFFFF;
  localparam logic [15:0] ICAP_SYNC1   = 16'hAA99;
  localparam logic [15:0] ICAP_SYNC2   = 16'h5566;
  localparam logic [15:0] ICAP_NOOP    = 16'h2000;
  localparam logic [15:0] ICAP_CMD_HDR = 16'h30A1;
  localparam logic [15:0] ICAP_IPROG   = 16'h000E;
  localparam logic [15:0] ICAP_DESYNC  = 16'h000D;
  localparam logic [15:0] ICAP_GEN1_HDR = 16'h3261;
  localparam logic [15:0] ICAP_GEN2_HDR = 16'h3281;
  localparam logic [15:0] ICAP_RD_HDR  = 16'h2801;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_STREAM = 3'd1,
    ST_RD_TURN   = 3'd2,
    ST_READ      = 3'd3,
    ST_WR_TURN   = 3'd4,
    ST_END       = 3'd5
  } icap_state_e;

  // Which fixed word stream the ROM is walking.
  typedef enum logic [1:0] {
    SEL_REBOOT = 2'd0,
    SEL_RD_PRE = 2'd1,
    SEL_RD_SUF = 2'd2
  } rom_sel_e;

  // Type-1 read header: word count 1, register address in bits [10:5].
  function automatic logic [15:0] rd_hdr(input logic [5:0] addr);
    return ICAP_RD_HDR | {5'b00000, addr, 5'b00000};
  endfunction

endpackage

// File: rtl/icap16_word_rom.sv
// ---------------------------------------------------------------------------
// icap16_word_rom
// Combinational lookup of the configuration word to drive on ICAP I.
//   sel       in  stream selector (reboot / read prefix / read desync suffix)
//   idx       in  word index within the selected stream
//   boot_addr in  multiboot flash address (reboot stream)
//   reg_addr  in  configuration register address (read prefix)
//   word      out word for (sel, idx)
//   last      out high when idx is the final word of the stream
// ---------------------------------------------------------------------------
module icap16_word_rom
  import icap16_pkg::*;
#(
  parameter logic [7:0] GEN2_OPCODE = 8'h03
) (
  input  rom_sel_e    sel,
  input  logic [3:0]  idx,
  input  logic [23:0] boot_addr,
  input  logic [5:0]  reg_addr,
  output logic [15:0] word,
  output logic        last
);

  always_comb begin
    word = ICAP_DUMMY;
    last = 1'b0;
    case (sel)
      SEL_REBOOT: begin
        case (idx)
          4'd0:  word = ICAP_DUMMY;
          4'd1:  word = ICAP_SYNC1;
          4'd2:  word = ICAP_SYNC2;
          4'd3:  word = ICAP_GEN1_HDR;
          4'd4:  word = boot_addr[15:0];
          4'd5:  word = ICAP_GEN2_HDR;
          4'd6:  word = {GEN2_OPCODE, boot_addr[23:16]};
          4'd7:  word = ICAP_CMD_HDR;
          4'd8:  word = ICAP_IPROG;
          4'd9:  word = ICAP_NOOP;
          4'd10: begin
            word = ICAP_NOOP;
            last = 1'b1;
          end
          default: ;
        endcase
      end
      SEL_RD_PRE: begin
        case (idx)
          4'd0: word = ICAP_DUMMY;
          4'd1: word = ICAP_SYNC1;
          4'd2: word = ICAP_SYNC2;
          4'd3: word = ICAP_NOOP;
          4'd4: word = rd_hdr(reg_addr);
          4'd5: word = ICAP_NOOP;
          4'd6: begin
            word = ICAP_NOOP;
            last = 1'b1;
          end
          default: ;
        endcase
      end
      SEL_RD_SUF: begin
        case (idx)
          4'd0: word = ICAP_CMD_HDR;
          4'd1: word = ICAP_DESYNC;
          4'd2: word = ICAP_NOOP;
          4'd3: begin
            word = ICAP_NOOP;
            last = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/icap16_cmd_seq.sv
// ---------------------------------------------------------------------------
// icap16_cmd_seq
// Sole driver of a 16-bit ICAP port. Plays fixed command streams for a
// multiboot reboot (op=0) or a single configuration-register read (op=1).
//   CLK, RST    clock, synchronous active-high reset
//   start       request pulse, accepted only while ready=1
//   op          0 = reboot, 1 = register read (sampled with start)
//   boot_addr   multiboot flash address (sampled with start)
//   reg_addr    configuration register address (sampled with start)
//   ready       idle, will accept start
//   done        one-cycle pulse at operation end
//   err         valid with done; 1 = read timed out
//   rd_data     last captured register value
//   icap_ce     ICAP CE (active-low), registered
//   icap_write  ICAP WRITE (0 write, 1 read), registered
//   icap_i      ICAP I, registered
//   icap_o      ICAP O
//   icap_busy   ICAP BUSY
// ---------------------------------------------------------------------------
module icap16_cmd_seq
  import icap16_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT  = 64,
  parameter int unsigned RD_SETTLE   = 2,
  parameter logic [7:0]  GEN2_OPCODE = 8'h03
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        op,
  input  logic [23:0] boot_addr,
  input  logic [5:0]  reg_addr,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_data,
  output logic        icap_ce,
  output logic        icap_write,
  output logic [15:0] icap_i,
  input  logic [15:0] icap_o,
  input  logic        icap_busy
);

  localparam int unsigned CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] SETTLE_C     = CNT_W'(RD_SETTLE);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  icap_state_e state_q, state_d;
  rom_sel_e    sel_q, sel_d;
  logic [3:0]  idx_q, idx_d;
  // Shared counter: turnaround phase (0/1) in RD_TURN/WR_TURN, elapsed
  // cycles in READ.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        word_last_q, word_last_d;
  logic [23:0] boot_addr_q, boot_addr_d;
  logic [5:0]  reg_addr_q, reg_addr_d;

  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        icap_ce_q, icap_ce_d;
  logic        icap_write_q, icap_write_d;
  logic [15:0] icap_i_q, icap_i_d;

  logic [15:0] rom_word;
  logic        rom_last;

  // The ROM looks up the word for the *next* cycle so that icap_i can be
  // registered; word_last_q then tells the current cycle whether the word
  // on the bus is the final one of its stream.
  icap16_word_rom #(
    .GEN2_OPCODE (GEN2_OPCODE)
  ) u_rom (
    .sel       (sel_d),
    .idx       (idx_d),
    .boot_addr (boot_addr_d),
    .reg_addr  (reg_addr_d),
    .word      (rom_word),
    .last      (rom_last)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    boot_addr_d = boot_addr_q;
    reg_addr_d  = reg_addr_q;
    err_d       = err_q;
    rd_data_d   = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start && ready_q) begin
          boot_addr_d = boot_addr;
          reg_addr_d  = reg_addr;
          err_d       = 1'b0;
          idx_d       = '0;
          sel_d       = op ? SEL_RD_PRE : SEL_REBOOT;
          state_d     = ST_WR_STREAM;
        end
      end

      ST_WR_STREAM: begin
        // BUSY=1 means the word was not taken: keep it on the bus.
        if (!icap_busy) begin
          if (word_last_q) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = (sel_q == SEL_RD_PRE) ? ST_RD_TURN : ST_END;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end

      ST_RD_TURN: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_ONE;
        end else begin
          cnt_d   = '0;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        // Capture wins over timeout when both happen in the final cycle.
        if ((cnt_q >= SETTLE_C) && !icap_busy) begin
          rd_data_d = icap_o;
          cnt_d     = '0;
          state_d   = ST_WR_TURN;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_WR_TURN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WR_TURN: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_ONE;
        end else begin
          cnt_d   = '0;
          idx_d   = '0;
          sel_d   = SEL_RD_SUF;
          state_d = ST_WR_STREAM;
        end
      end

      ST_END: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Port outputs are a function of the next state so they can be registered
  // without adding a cycle of latency. Turnaround phases split CE and WRITE
  // changes into separate cycles.
  always_comb begin
    icap_ce_d    = 1'b1;
    icap_write_d = 1'b0;
    icap_i_d     = ICAP_DUMMY;
    case (state_d)
      ST_WR_STREAM: begin
        icap_ce_d = 1'b0;
        icap_i_d  = rom_word;
      end
      ST_RD_TURN: icap_write_d = (cnt_d != '0);
      ST_READ: begin
        icap_ce_d    = 1'b0;
        icap_write_d = 1'b1;
      end
      ST_WR_TURN: icap_write_d = (cnt_d == '0);
      default: ;
    endcase
    ready_d     = (state_d == ST_IDLE);
    done_d      = (state_d == ST_END);
    word_last_d = rom_last;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      sel_q        <= SEL_REBOOT;
      idx_q        <= '0;
      cnt_q        <= '0;
      word_last_q  <= 1'b0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      icap_ce_q    <= 1'b1;
      icap_write_q <= 1'b0;
      icap_i_q     <= ICAP_DUMMY;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      word_last_q  <= word_last_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_data_q    <= rd_data_d;
      icap_ce_q    <= icap_ce_d;
      icap_write_q <= icap_write_d;
      icap_i_q     <= icap_i_d;
    end
  end

  // Request operands are only meaningful while an operation runs.
  always_ff @(posedge CLK) begin
    boot_addr_q <= boot_addr_d;
    reg_addr_q  <= reg_addr_d;
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rd_data    = rd_data_q;
  assign icap_ce    = icap_ce_q;
  assign icap_write = icap_write_q;
  assign icap_i     = icap_i_q;

endmodule

// File: tb/tb_icap16_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_icap16_cmd_seq
// Self-checking bench: a behavioural ICAP model answers reads and injects
// BUSY stalls; expected word streams, capture values, error flags and
// latencies come from the operation tables and timing rules.
// ---------------------------------------------------------------------------
module tb_icap16_cmd_seq;

  localparam int RD_TIMEOUT = 64;
  localparam int RD_SETTLE  = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [23:0] boot_addr = '0;
  logic [5:0]  reg_addr = '0;
  logic        ready, done, err;
  logic [15:0] rd_data;
  logic        icap_ce, icap_write;
  logic [15:0] icap_i;
  logic [15:0] icap_o = '0;
  logic        icap_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int proto_viol = 0;
  logic prev_ce, prev_we;
  bit   prev_valid = 1'b0;

  logic [15:0] m_rd_data = '0;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];

  always #5 CLK = ~CLK;

  icap16_cmd_seq dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .op         (op),
    .boot_addr  (boot_addr),
    .reg_addr   (reg_addr),
    .ready      (ready),
    .done       (done),
    .err        (err),
    .rd_data    (rd_data),
    .icap_ce    (icap_ce),
    .icap_write (icap_write),
    .icap_i     (icap_i),
    .icap_o     (icap_o),
    .icap_busy  (icap_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // CE and WRITE must never change on the same clock.
  always @(negedge CLK) begin
    if (RST) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid) begin
        assert (!((icap_ce !== prev_ce) && (icap_write !== prev_we)))
          else $error("ce and write changed in the same cycle");
        if ((icap_ce !== prev_ce) && (icap_write !== prev_we)) proto_viol <= proto_viol + 1;
      end
      prev_valid <= 1'b1;
      prev_ce    <= icap_ce;
      prev_we    <= icap_write;
    end
  end

  // Words the ICAP should accept, in order, for one operation.
  task automatic build_exp(input bit o, input logic [23:0] ba, input logic [5:0] ra);
    exp_q.delete();
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'hAA99);
    exp_q.push_back(16'h5566);
    if (!o) begin
      exp_q.push_back(16'h3261);
      exp_q.push_back(ba[15:0]);
      exp_q.push_back(16'h3281);
      exp_q.push_back({8'h03, ba[23:16]});
      exp_q.push_back(16'h30A1);
      exp_q.push_back(16'h000E);
      exp_q.push_back(16'h2000);
      exp_q.push_back(16'h2000);
    end else begin
      exp_q.push_back(16'h2000);
      exp_q.push_back(16'h2801 + 16'(ra) * 16'd32);
      exp_q.push_back(16'h2000);
      exp_q.push_back(16'h2000);
      exp_q.push_back(16'h30A1);
      exp_q.push_back(16'h000D);
      exp_q.push_back(16'h2000);
      exp_q.push_back(16'h2000);
    end
  endtask

  // Runs one operation starting at a negedge with the DUT idle; ends at the
  // negedge after done.
  //   stall_word/stall_len : hold BUSY for stall_len cycles on that word index
  //   stall_pct            : random write-stall probability
  //   rd_lat               : BUSY=1 for the first rd_lat read cycles (-1: random)
  //   rd_val               : value returned when BUSY=0 in a read cycle
  //   poke_start           : issue a second start mid-operation
  task automatic run_op(input bit o, input logic [23:0] ba, input logic [5:0] ra,
                        input int stall_word, input int stall_len, input int stall_pct,
                        input int rd_lat, input logic [15:0] rd_val, input bit poke_start);
    int n, wr_stalls, rc, exp_rc, hold_err, stall_done, pre_rd_words, lat;
    bit captured, was_held, got_done, ready_low, err_at1;
    logic [15:0] held_word;
    logic [15:0] d;
    build_exp(o, ba, ra);
    got_q.delete();
    n = 0; wr_stalls = 0; rc = 0; exp_rc = RD_TIMEOUT; hold_err = 0; stall_done = 0;
    pre_rd_words = -1; lat = 0;
    captured = 1'b0; was_held = 1'b0; got_done = 1'b0; ready_low = 1'b0; err_at1 = 1'b1;
    held_word = '0;
    start = 1'b1; op = o; boot_addr = ba; reg_addr = ra;
    @(posedge CLK);
    while (!got_done && n < 400) begin
      @(negedge CLK);
      n++;
      start = 1'b0;
      if (n == 1) begin
        ready_low = (ready == 1'b0);
        err_at1   = err;
      end
      if (was_held) begin
        if (!(icap_ce == 1'b0 && icap_write == 1'b0 && icap_i == held_word)) hold_err++;
        was_held = 1'b0;
      end
      if (done) begin
        got_done = 1'b1;
        lat = n;
      end else if (icap_ce == 1'b0 && icap_write == 1'b0) begin
        icap_busy = 1'b0;
        if (stall_word == got_q.size() && stall_done < stall_len) begin
          icap_busy = 1'b1;
          stall_done++;
        end else if (int'($urandom_range(99)) < stall_pct) begin
          icap_busy = 1'b1;
        end
        if (icap_busy) begin
          wr_stalls++;
          was_held = 1'b1;
          held_word = icap_i;
        end else begin
          got_q.push_back(icap_i);
        end
      end else if (icap_ce == 1'b0 && icap_write == 1'b1) begin
        if (rc == 0) pre_rd_words = got_q.size();
        if (rd_lat >= 0) icap_busy = (rc < rd_lat);
        else icap_busy = 1'($urandom_range(1));
        d = icap_busy ? 16'($urandom) : rd_val;
        icap_o = d;
        if (!captured && rc < RD_TIMEOUT && rc >= RD_SETTLE && !icap_busy) begin
          captured  = 1'b1;
          m_rd_data = d;
          exp_rc    = rc + 1;
        end
        rc++;
      end else begin
        icap_busy = 1'($urandom_range(1));
        icap_o    = 16'($urandom);
      end
      if (poke_start && n == 3) begin
        start = 1'b1; op = ~o; boot_addr = 24'($urandom); reg_addr = 6'($urandom);
      end
    end
    chk("done_seen", 32'(got_done), 32'd1);
    chk("ready_drop", 32'(ready_low), 32'd1);
    chk("err_clear_on_start", 32'(err_at1), 32'd0);
    chk("n_words", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("word%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    chk("busy_hold", 32'(hold_err), 32'd0);
    chk("err", 32'(err), 32'(o && !captured));
    chk("rd_data", 32'(rd_data), 32'(m_rd_data));
    if (o) begin
      chk("rd_cycles", 32'(rc), 32'(exp_rc));
      chk("pre_rd_words", 32'(pre_rd_words), 32'd7);
    end
    chk("latency", 32'(lat), 32'(exp_q.size() + wr_stalls + (o ? 4 + exp_rc : 0) + 1));
    chk("ce_we_proto", 32'(proto_viol), 32'd0);
    icap_busy = 1'b0;
    @(negedge CLK);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog no_finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    bit ro;
    int rl;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_ce", 32'(icap_ce), 32'd1);
    chk("rst_write", 32'(icap_write), 32'd0);
    chk("rst_i", 32'(icap_i), 32'hFFFF);

    // Directed reboot, no stalls.
    run_op(1'b0, 24'h123456, 6'h00, -1, 0, 0, -1, 16'h0000, 1'b0);
    // Directed read of register 0x0C answering BEEF on the fourth read cycle.
    run_op(1'b1, 24'h000000, 6'h0C, -1, 0, 0, 3, 16'hBEEF, 1'b0);
    chk("read_beef", 32'(rd_data), 32'hBEEF);
    // Timeout: BUSY held through the whole read window.
    run_op(1'b1, 24'h000000, 6'h15, -1, 0, 0, 1000, 16'h1234, 1'b1);
    chk("timeout_keep", 32'(rd_data), 32'hBEEF);
    // Reboot with a 3-cycle stall on the fifth word.
    run_op(1'b0, 24'hA5C3F0, 6'h00, 4, 3, 0, -1, 16'h0000, 1'b1);

    // Randomized operations.
    for (int t = 0; t < 14; t++) begin
      ro = 1'($urandom_range(1));
      rl = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(70));
      run_op(ro, 24'($urandom), 6'($urandom),
             ($urandom_range(1) == 1) ? int'($urandom_range(10)) : -1,
             int'($urandom_range(1, 4)), 15, rl, 16'($urandom), 1'b1);
    end

    // Reset in the middle of a reboot stream.
    icap_busy = 1'b0;
    start = 1'b1; op = 1'b0; boot_addr = 24'hABCDEF; reg_addr = '0;
    @(posedge CLK);
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    chk("rst_mid_word6", 32'(icap_i), 32'h3281);
    RST = 1'b1;
    @(negedge CLK);
    m_rd_data = '0;
    chk("rst_mid_ce", 32'(icap_ce), 32'd1);
    chk("rst_mid_write", 32'(icap_write), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_i", 32'(icap_i), 32'hFFFF);
    chk("rst_mid_rd_data", 32'(rd_data), 32'(m_rd_data));
    RST = 1'b0;
    nd = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done) nd++;
    end
    chk("rst_mid_no_done", 32'(nd), 32'd0);

    // Recovery after reset.
    run_op(1'b1, 24'h000000, 6'h2A, -1, 0, 10, 5, 16'h5A5A, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
